// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths and write-back request type
package regfile_pkg;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      value;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-input round-robin arbiter, combinational one-hot grant plus last-grant pointer
module rr_arbiter #(
  parameter  int N     = 3,
  localparam int IDX_W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] cand_idx;
  logic [IDX_W-1:0] win_idx;
  logic             found;
  int               cand;

  // Scan last+1, last+2, ... wrapping at N; the first valid request wins.
  always_comb begin
    gnt      = '0;
    found    = 1'b0;
    win_idx  = last_q;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= N; i++) begin
      cand = int'(last_q) + i;
      if (cand >= N) cand = cand - N;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found         = 1'b1;
        gnt[cand_idx] = 1'b1;
        win_idx       = cand_idx;
      end
    end
    last_d = found ? win_idx : last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= IDX_W'(N - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - register file write-port scheduler with busy scoreboard; WB_FORWARD_EN adds write-cycle forwarding
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [REG_IDX_W*N_REQ-1:0] req_rd,
  input  logic [XLEN*N_REQ-1:0]      req_value,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       issue_valid,
  input  logic [REG_IDX_W-1:0]       issue_rd,
  input  logic [REG_IDX_W-1:0]       issue_rs1,
  input  logic [REG_IDX_W-1:0]       issue_rs2,
  output logic                       issue_stall,
  output logic                       rf_we,
  output logic [REG_IDX_W-1:0]       rf_rd,
  output logic [XLEN-1:0]            rf_wdata,
  output logic [NUM_REGS-1:0]        busy
`ifdef WB_FORWARD_EN
  ,
  output logic                       fwd_rs1_valid,
  output logic [XLEN-1:0]            fwd_rs1_data,
  output logic                       fwd_rs2_valid,
  output logic [XLEN-1:0]            fwd_rs2_data
`endif
);

  logic [N_REQ-1:0]     arb_req, gnt;
  wb_req_t              win;
  logic                 xfer;
  logic                 rf_we_q, rf_we_d;
  logic [REG_IDX_W-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]      rf_wdata_q, rf_wdata_d;
  logic [NUM_REGS-1:0]  busy_q, busy_d;
  logic [NUM_REGS-1:0]  fwd_vec, hz_vec;
  logic                 accept;

  // Masking requests under reset keeps req_ready low while rst is held.
  always_comb arb_req = rst ? '0 : req_valid;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (arb_req),
    .gnt (gnt)
  );

  assign req_ready = gnt;

  always_comb begin
    win  = '0;
    xfer = |gnt;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        win.rd    = req_rd[REG_IDX_W*k +: REG_IDX_W];
        win.value = req_value[XLEN*k +: XLEN];
      end
    end
    // A grant to x0 is consumed but never reaches the register file.
    rf_we_d    = xfer && (win.rd != '0);
    rf_rd_d    = xfer ? win.rd : rf_rd_q;
    rf_wdata_d = xfer ? win.value : rf_wdata_q;
  end

  always_comb begin
`ifdef WB_FORWARD_EN
    fwd_vec = rf_we_q ? (NUM_REGS'(1) << rf_rd_q) : '0;
`else
    fwd_vec = '0;
`endif
    hz_vec      = busy_q & ~fwd_vec;
    issue_stall = !rst && issue_valid &&
                  (hz_vec[issue_rs1] || hz_vec[issue_rs2] || hz_vec[issue_rd]);
    accept      = issue_valid && !issue_stall;
    // Clear first, then set: a newly issued producer owns the register.
    busy_d = busy_q;
    if (rf_we_q) busy_d[rf_rd_q] = 1'b0;
    if (accept && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

`ifdef WB_FORWARD_EN
  always_comb begin
    fwd_rs1_valid = rf_we_q && (rf_rd_q == issue_rs1);
    fwd_rs2_valid = rf_we_q && (rf_rd_q == issue_rs2);
    fwd_rs1_data  = rf_wdata_q;
    fwd_rs2_data  = rf_wdata_q;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler for the 32x32 integer register file. It shares the register file's single write port between N_REQ result producers (ALU, load unit, CSR/mul) using round-robin arbitration. It keeps a busy-bit scoreboard of destination registers with writes in flight, and gives decode a hazard/stall indication. It sits between the execute units and the register file write port (register_write / rd / rd_value).

## Interface
- N_REQ, default 3: number of write-back requesters, 2..8.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester write request.
- req_rd  in  5*N_REQ  destination index; requester k uses bits [5k+4:5k].
- req_value  in  32*N_REQ  write data; requester k uses bits [32k+31:32k].
- req_ready  out  N_REQ  one-hot grant; a transfer occurs when req_valid[k] && req_ready[k].
- issue_valid  in  1  decode wants to issue an instruction.
- issue_rd  in  5  destination of the issuing instruction; 0 means no write-back.
- issue_rs1, issue_rs2  in  5 each  source indices of the issuing instruction.
- issue_stall  out  1  hazard; the instruction is not accepted this cycle.
- rf_we  out  1  to register file register_write.
- rf_rd  out  5  to register file rd.
- rf_wdata  out  32  to register file rd_value.
- busy  out  32  scoreboard bits; bit 0 is constant 0.

## Operation
- Arbitration is combinational from req_valid and the pointer last_gnt.
  - The winner is the first valid index scanning last_gnt+1, last_gnt+2, ... modulo N_REQ.
  - If there are no valid requests, req_ready is all zero.
  - req_ready is never asserted for a non-valid requester.
  - At most one bit of req_ready is set.
- On a transfer:
  - last_gnt is set to the winner.
  - The output stage loads rf_we=1, rf_rd=req_rd[winner] and rf_wdata=req_value[winner].
- With no transfer, rf_we=0 next cycle. rf_rd/rf_wdata hold their last values.
- A transfer with req_rd==0 still consumes a grant but drives rf_we=0.
- Scoreboard: busy[r] marks register r as owed a write.
  - Set: issue accepted (issue_valid && !issue_stall) with issue_rd!=0 sets busy[issue_rd].
  - Clear: rf_we && rf_rd==r clears busy[r] at the edge on which the register file captures the data.
  - Set and clear of the same r on the same edge: set wins, because the newer producer owns the register.
- issue_stall = issue_valid && (hz(issue_rs1) || hz(issue_rs2) || hz(issue_rd)).
  - hz(r) = (r!=0) && busy[r] && !fwd_hit(r).
  - A busy destination stalls (WAW), so at most one in-flight write exists per register.
- Producers must only present writes for registers whose issue was accepted. The scheduler does not check this.

## Timing
- Grant to register file write: 1 cycle.
  - Transfer in cycle t → rf_we=1 in cycle t+1.
  - The register file updates at the end of t+1.
  - busy clears at the same edge.
  - A reader sees the new value in t+2.
- One write per cycle sustained. req_ready is combinational, with no bubble between back-to-back grants.
- Issue-to-busy: accepted in cycle t, busy visible in t+1.
- Reset values: rf_we=0, rf_rd=0, rf_wdata=0, busy=0, last_gnt=N_REQ-1 (requester 0 wins first).
  - req_ready and issue_stall are combinational and therefore 0 under reset.
- Reset asserted mid-operation:
  - An in-flight rf_we is dropped and the scoreboard is cleared.
  - Requesters must re-present after reset deasserts.

## Configuration
- WB_FORWARD_EN defined:
  - fwd_hit(r) = rf_we && rf_rd==r.
  - Adds outputs fwd_rs1_valid, fwd_rs1_data, fwd_rs2_valid, fwd_rs2_data (rf_wdata when the hit applies).
  - Decode may issue in the write cycle t+1 using forwarded data. The stall is removed one cycle earlier.
- WB_FORWARD_EN undefined:
  - fwd_hit is constant 0 and the forwarding ports are absent.
  - A consumer stalls through t+1 and issues in t+2.

## Structure
- Shared package regfile_pkg holds:
  - REG_IDX_W=5, XLEN=32, NUM_REGS=32.
  - A typedef for a write-back request {rd, value}.
- Sub-module rr_arbiter (N-input round-robin, combinational grant plus pointer register) is instantiated once. It is reusable for other shared ports.

## Test plan
- Reset, then req_valid=3'b111 held with rd=1,2,3 and values 0xA,0xB,0xC → grants req0, req1, req2, req0 on consecutive cycles; rf_we=1 from cycle 2 with rf_rd=1,2,3.
- Only req2 valid with rd=5, value 0xDEADBEEF → req_ready=3'b100; next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF.
- Issue rd=7, then issue rs1=7 every cycle, writing x7 three cycles later:
  - without WB_FORWARD_EN, stall until the cycle after rf_we;
  - with it, the stall drops during the rf_we cycle and fwd_rs1_data equals the written value.
- Issue rd=9 in the same cycle that rf_we writes x9 → busy[9]=1 afterwards (set wins).
- Transfer with req_rd=0 → rf_we=0 next cycle and busy unchanged; issue with rs1=0 never stalls.
- Assert rst while busy=0x0000_0F00 and rf_we=1 → all outputs at reset values immediately; first post-reset grant goes to req0.
